// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Shared opcode, format, error-code and FSM-state constants for
//               the Simple-RISC instruction encoder/loader.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

  localparam logic [2:0] OP_ILL  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_BL   = 3'b010;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [15:0] HALT_WORD = 16'hE000;

  typedef enum logic [2:0] {
    FMT_IMM8,
    FMT_IMM5,
    FMT_REG,
    FMT_HALT,
    FMT_ILL
  } fmt_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEPT = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FULL   = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module      : instr_pack
// Description : Combinational packing of decoded fields into a 16-bit word,
//               with format classification and immediate range check.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  opcode,
  input  logic [1:0]  op,
  input  logic [2:0]  cond,
  input  logic [2:0]  rn,
  input  logic [2:0]  rd,
  input  logic [2:0]  rm,
  input  logic [1:0]  shift,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output fmt_e        fmt,
  output logic        range_err
);

  logic imm8_ok;
  logic imm5_ok;

  always_comb begin
    // Signed fit: every bit above the sign bit of the field matches it
    imm8_ok = (imm[15:7] == 9'h000) || (imm[15:7] == 9'h1FF);
    imm5_ok = (imm[15:4] == 12'h000) || (imm[15:4] == 12'hFFF);
    fmt     = FMT_ILL;
    word    = 16'h0000;
    case (opcode)
      OP_BR: begin
        fmt  = FMT_IMM8;
        word = {opcode, op, cond, imm[7:0]};
      end
      OP_BL: begin
        if (op == 2'b11) begin
          fmt  = FMT_IMM8;
          word = {opcode, op, rn, imm[7:0]};
        end else if (op != 2'b01) begin
          fmt  = FMT_REG;
          word = {opcode, op, rn, rd, shift, rm};
        end
      end
      OP_LDR, OP_STR: begin
        fmt  = FMT_IMM5;
        word = {opcode, op, rn, rd, imm[4:0]};
      end
      OP_ALU: begin
        fmt  = FMT_REG;
        word = {opcode, op, rn, rd, shift, rm};
      end
      OP_MOV: begin
        if (op == 2'b10) begin
          fmt  = FMT_IMM8;
          word = {opcode, op, rn, imm[7:0]};
        end else if (op == 2'b00) begin
          fmt  = FMT_REG;
          word = {opcode, op, 3'b000, rd, shift, rm};
        end
      end
      OP_HALT: begin
        fmt  = FMT_HALT;
        word = HALT_WORD;
      end
      default: ;
    endcase
    range_err = ((fmt == FMT_IMM8) && !imm8_ok) || ((fmt == FMT_IMM5) && !imm5_ok);
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Accepts decoded field bundles, encodes them and writes the
//               words to instruction memory at auto-incrementing addresses.
//               Optional macro ENC_CHECKSUM_EN adds an XOR checksum output.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [1:0]        op,
  input  logic [2:0]        cond,
  input  logic [2:0]        rn,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [1:0]        shift,
  input  logic [15:0]       imm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_wr_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              full,
  output logic              err,
`ifdef ENC_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              halt_q, halt_d;
  logic [15:0]       csum_q, csum_d;

  logic [15:0] pack_word;
  fmt_e        pack_fmt;
  logic        pack_range_err;

  instr_pack u_pack (
    .opcode    (opcode),
    .op        (op),
    .cond      (cond),
    .rn        (rn),
    .rd        (rd),
    .rm        (rm),
    .shift     (shift),
    .imm       (imm),
    .word      (pack_word),
    .fmt       (pack_fmt),
    .range_err (pack_range_err)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    count_d    = count_q;
    done_d     = done_q;
    full_d     = full_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    halt_d     = halt_q;
    csum_d     = csum_q;
    // start outranks everything, including abandoning a pending write
    if (start) begin
      state_d    = ST_ACCEPT;
      addr_d     = base_addr;
      count_d    = '0;
      done_d     = 1'b0;
      full_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      halt_d     = 1'b0;
      csum_d     = 16'h0000;
    end else begin
      case (state_q)
        ST_ACCEPT: begin
          if (in_valid) begin
            if (pack_fmt == FMT_ILL) begin
              err_d      = 1'b1;
              err_code_d = ERR_ILLEGAL;
              state_d    = ST_ERROR;
            end else if (pack_range_err) begin
              err_d      = 1'b1;
              err_code_d = ERR_RANGE;
              state_d    = ST_ERROR;
            end else begin
              wdata_d = pack_word;
              halt_d  = (pack_fmt == FMT_HALT);
              state_d = ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (mem_wr_ready) begin
            count_d = count_q + (ADDR_W+1)'(1);
            csum_d  = csum_q ^ wdata_q;
            if (halt_q) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else if (addr_q == LAST_ADDR) begin
              full_d  = 1'b1;
              state_d = ST_FULL;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_ACCEPT;
            end
          end
        end
        ST_FULL: begin
          if (in_valid) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVERFLOW;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= 16'h0000;
      count_q    <= '0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      halt_q     <= 1'b0;
      csum_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      count_q    <= count_d;
      done_q     <= done_d;
      full_q     <= full_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      halt_q     <= halt_d;
      csum_q     <= csum_d;
    end
  end

  assign in_ready   = (state_q == ST_ACCEPT);
  assign mem_we     = (state_q == ST_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

`ifdef ENC_CHECKSUM_EN
  assign checksum = csum_q;
`else
  logic unused_csum;
  assign unused_csum = ^csum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Self-checking bench for instr_encoder_loader with a write
//               scoreboard. Honours ENC_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 128;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        cond;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [2:0]        rm;
  logic [1:0]        shift;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              mem_wr_ready;
  logic [ADDR_W:0]   word_count;
  logic              done;
  logic              full;
  logic              err;
  logic [1:0]        err_code;
`ifdef ENC_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t exp_q[$];

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .op           (op),
    .cond         (cond),
    .rn           (rn),
    .rd           (rd),
    .rm           (rm),
    .shift        (shift),
    .imm          (imm),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_wr_ready (mem_wr_ready),
    .word_count   (word_count),
    .done         (done),
    .full         (full),
    .err          (err),
`ifdef ENC_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .err_code     (err_code)
  );

  always #5 clk = ~clk;

  // Every completed write must match the oldest expected write
  always @(negedge clk) begin : p_monitor
    wr_t e;
    if (reset_n === 1'b1 && mem_we === 1'b1 && mem_wr_ready === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("FAIL sb_write: addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b);
    start     = 1'b1;
    base_addr = b;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] f_opc, input logic [1:0] f_op, input logic [2:0] f_cond,
                      input logic [2:0] f_rn, input logic [2:0] f_rd, input logic [2:0] f_rm,
                      input logic [1:0] f_sh, input logic [15:0] f_imm);
    int n;
    n = 0;
    opcode = f_opc; op = f_op; cond = f_cond; rn = f_rn; rd = f_rd; rm = f_rm;
    shift = f_sh; imm = f_imm; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    tests++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, word_count, done, full, err, err_code} !== '0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h cnt=%0d done=%b full=%b err=%b code=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, word_count, done, full, err, err_code);
    end
`ifdef ENC_CHECKSUM_EN
    tests++;
    if (checksum !== 16'h0000) begin
      fails++;
      $display("FAIL reset_checksum: %h, required 0000", checksum);
    end
`endif
    reset_n = 1'b1;
    tick(2);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL idle_ready: in_ready=%b, required 0", in_ready);
    end
  endtask

  task automatic test_mov();
    mem_wr_ready = 1'b1;
    pulse_start(8'h10);
    tests++;
    if (in_ready !== 1'b1 || word_count !== 9'd0 || mem_addr !== 8'h10) begin
      fails++;
      $display("FAIL start_state: rdy=%b cnt=%0d addr=%h, required 1 0 10", in_ready, word_count, mem_addr);
    end
    expect_write(8'h10, 16'hD3FB);
    send(3'b110, 2'b10, 3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    tests++;
    if (mem_we !== 1'b1 || mem_wdata !== 16'hD3FB) begin
      fails++;
      $display("FAIL mov_latency: we=%b data=%h, required 1 d3fb", mem_we, mem_wdata);
    end
    tick(1);
    tests++;
    if (word_count !== 9'd1 || mem_addr !== 8'h11 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mov_after: cnt=%0d addr=%h rdy=%b, required 1 11 1", word_count, mem_addr, in_ready);
    end
  endtask

  task automatic test_stall();
    mem_wr_ready = 1'b0;
    expect_write(8'h11, 16'hA14C);
    send(3'b101, 2'b00, 3'd0, 3'd1, 3'd2, 3'd4, 2'd1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({mem_we, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b0, 8'h11, 16'hA14C}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: we=%b rdy=%b addr=%h data=%h, required 1 0 11 a14c",
                 i, mem_we, in_ready, mem_addr, mem_wdata);
      end
      tick(1);
    end
    mem_wr_ready = 1'b1;
    tick(1);
    tests++;
    if (word_count !== 9'd2 || mem_addr !== 8'h12) begin
      fails++;
      $display("FAIL stall_release: cnt=%0d addr=%h, required 2 12", word_count, mem_addr);
    end
  endtask

  task automatic test_range();
    send(3'b011, 2'b00, 3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 16'd16);
    tick(2);
    tests++;
    if ({err, err_code, mem_we, in_ready} !== {1'b1, 2'b10, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL imm5_over: err=%b code=%b we=%b rdy=%b, required 1 10 0 0", err, err_code, mem_we, in_ready);
    end
    pulse_start(8'h20);
    tests++;
    if (err !== 1'b0 || err_code !== 2'b00) begin
      fails++;
      $display("FAIL start_clears_err: err=%b code=%b, required 0 00", err, err_code);
    end
    expect_write(8'h20, 16'h6110);
    send(3'b011, 2'b00, 3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 16'hFFF0);
    tick(1);
    send(3'b110, 2'b10, 3'd0, 3'd2, 3'd0, 3'd0, 2'd0, 16'd128);
    tests++;
    if ({err, err_code, mem_we} !== {1'b1, 2'b10, 1'b0}) begin
      fails++;
      $display("FAIL imm8_over: err=%b code=%b we=%b, required 1 10 0", err, err_code, mem_we);
    end
    pulse_start(8'h30);
    expect_write(8'h30, 16'hD080);
    send(3'b110, 2'b10, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFF80);
    tick(1);
  endtask

  task automatic test_illegal();
    send(3'b000, 2'b00, 3'd0, 3'd1, 3'd1, 3'd1, 2'd0, 16'h0000);
    tick(1);
    tests++;
    if ({err, err_code, mem_we, in_ready, word_count} !== {1'b1, 2'b01, 1'b0, 1'b0, 9'd1}) begin
      fails++;
      $display("FAIL illegal_op: err=%b code=%b we=%b rdy=%b cnt=%0d, required 1 01 0 0 1",
               err, err_code, mem_we, in_ready, word_count);
    end
  endtask

  task automatic test_encodings();
    pulse_start(8'h60);
    expect_write(8'h60, 16'h2D80);
    send(3'b001, 2'b01, 3'd5, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFF80);
    tick(1);
    expect_write(8'h61, 16'h82EF);
    send(3'b100, 2'b00, 3'd0, 3'd2, 3'd7, 3'd0, 2'd0, 16'd15);
    tick(1);
    expect_write(8'h62, 16'h5E7F);
    send(3'b010, 2'b11, 3'd0, 3'd6, 3'd0, 3'd0, 2'd0, 16'd127);
    tick(1);
    expect_write(8'h63, 16'hC071);
    send(3'b110, 2'b00, 3'd0, 3'd5, 3'd3, 3'd1, 2'd2, 16'h0000);
    tick(1);
    tests++;
    if (word_count !== 9'd4 || err !== 1'b0) begin
      fails++;
      $display("FAIL encodings_count: cnt=%0d err=%b, required 4 0", word_count, err);
    end
  endtask

  task automatic test_full();
    pulse_start(8'(DEPTH - 2));
    expect_write(8'(DEPTH - 2), 16'hD3FB);
    send(3'b110, 2'b10, 3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    tick(1);
    expect_write(8'(DEPTH - 1), 16'hD107);
    send(3'b110, 2'b10, 3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 16'd7);
    tick(1);
    tests++;
    if ({full, in_ready, err, word_count, mem_addr} !== {1'b1, 1'b0, 1'b0, 9'd2, 8'(DEPTH - 1)}) begin
      fails++;
      $display("FAIL full_set: full=%b rdy=%b err=%b cnt=%0d addr=%h, required 1 0 0 2 %h",
               full, in_ready, err, word_count, mem_addr, 8'(DEPTH - 1));
    end
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    tick(2);
    tests++;
    if ({err, err_code, full, in_ready, mem_we, word_count} !== {1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 9'd2}) begin
      fails++;
      $display("FAIL full_overflow: err=%b code=%b full=%b rdy=%b we=%b cnt=%0d, required 1 11 1 0 0 2",
               err, err_code, full, in_ready, mem_we, word_count);
    end
  endtask

  task automatic test_halt();
    pulse_start(8'h40);
    expect_write(8'h40, 16'hD3FB);
    send(3'b110, 2'b10, 3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    tick(1);
    expect_write(8'h41, 16'hD107);
    send(3'b110, 2'b10, 3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 16'd7);
    tick(1);
    expect_write(8'h42, 16'hE000);
    send(3'b111, 2'b01, 3'd3, 3'd3, 3'd3, 3'd3, 2'd3, 16'h1234);
    tests++;
    if (mem_we !== 1'b1 || mem_wdata !== 16'hE000) begin
      fails++;
      $display("FAIL halt_word: we=%b data=%h, required 1 e000", mem_we, mem_wdata);
    end
    tick(1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({done, in_ready, word_count} !== {1'b1, 1'b0, 9'd3}) begin
        fails++;
        $display("FAIL halt_done[%0d]: done=%b rdy=%b cnt=%0d, required 1 0 3", i, done, in_ready, word_count);
      end
      tick(1);
    end
    in_valid = 1'b0;
    pulse_start(8'h50);
    tests++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL halt_restart: done=%b rdy=%b, required 0 1", done, in_ready);
    end
  endtask

  task automatic test_restart_in_write();
    mem_wr_ready = 1'b0;
    send(3'b110, 2'b10, 3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    pulse_start(8'h58);
    tests++;
    if ({mem_we, in_ready, mem_addr, word_count} !== {1'b0, 1'b1, 8'h58, 9'd0}) begin
      fails++;
      $display("FAIL restart_write: we=%b rdy=%b addr=%h cnt=%0d, required 0 1 58 0",
               mem_we, in_ready, mem_addr, word_count);
    end
    mem_wr_ready = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    mem_wr_ready = 1'b0;
    send(3'b110, 2'b10, 3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    tests++;
    if (mem_we !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_write: we=%b, required 1", mem_we);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, word_count, done, full, err, err_code} !== '0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b we=%b addr=%h data=%h cnt=%0d done=%b full=%b err=%b code=%b, required all 0",
               in_ready, mem_we, mem_addr, mem_wdata, word_count, done, full, err, err_code);
    end
    tick(2);
    reset_n      = 1'b1;
    mem_wr_ready = 1'b1;
    tick(1);
  endtask

`ifdef ENC_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start(8'h70);
    tests++;
    if (checksum !== 16'h0000) begin
      fails++;
      $display("FAIL checksum_clear: %h, required 0000", checksum);
    end
    expect_write(8'h70, 16'hD3FB);
    send(3'b110, 2'b10, 3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFB);
    tick(1);
    expect_write(8'h71, 16'hE000);
    send(3'b111, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000);
    tick(1);
    tests++;
    if (checksum !== 16'h33FB) begin
      fails++;
      $display("FAIL checksum_value: %h, required 33fb", checksum);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    opcode = '0; op = '0; cond = '0; rn = '0; rd = '0; rm = '0; shift = '0; imm = '0;
    mem_wr_ready = 1'b0;
    test_reset();
    test_mov();
    test_stall();
    test_range();
    test_illegal();
    test_encodings();
    test_full();
    test_halt();
    test_restart_in_write();
    test_reset_mid_write();
`ifdef ENC_CHECKSUM_EN
    test_checksum();
`endif
    tick(2);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
